// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared constants for the data-cache port arbiter:
//   - FSM state encoding (exposed on the arbiter debug port)
//   - requester identifiers used by the round-robin last_grant register
//   - bit positions of the 4-bit exception vector {pf, misaligned, access, bus}
//   - fixed op/size driven for page-table-walker reads (load doubleword)
// -----------------------------------------------------------------------------
package drac_pkg;

    // FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_EXE = 2'd1;
    localparam logic [1:0] ST_WAIT_PTW = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    // Requester identity as stored in last_grant
    localparam logic GNT_EXE = 1'b0;
    localparam logic GNT_PTW = 1'b1;

    // Exception vector bit positions
    localparam int XCPT_BUS_BIT      = 0;
    localparam int XCPT_ACCESS_BIT   = 1;
    localparam int XCPT_MISALIGN_BIT = 2;
    localparam int XCPT_PF_BIT       = 3;

    // Exception vector reported on a response timeout
    localparam logic [3:0] XCPT_BUS = 4'(1 << XCPT_BUS_BIT);

    // Page-table-walker request: load doubleword, 8 bytes
    localparam logic [6:0] PTW_OP   = 7'b0000011;
    localparam logic [2:0] PTW_SIZE = 3'd3;

endpackage

// File: rtl/dcache_port_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant selection.
//   req_exe_i    : execute-stage request (already qualified by kill)
//   req_ptw_i    : page-table-walker request
//   last_grant_i : requester granted last (GNT_EXE / GNT_PTW)
//   grant_o      : one-hot grant, bit 0 = EXE, bit 1 = PTW
// A lone requester always wins; on a tie the one not granted last wins.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import drac_pkg::*;
(
    input  logic       req_exe_i,
    input  logic       req_ptw_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = req_exe_i & (~req_ptw_i | (last_grant_i == GNT_PTW));
        grant_o[1] = req_ptw_i & (~req_exe_i | (last_grant_i == GNT_EXE));
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
// Shares one data-cache request port between the execute stage (EXE) and the
// page-table walker (PTW), with at most one request outstanding.
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   exe_req_*_i / exe_kill_i     execute-stage request and flush
//   exe_req_ready_o              EXE request accepted this cycle
//   ptw_req_valid_i/addr_i       PTW read request (8-byte load)
//   ptw_req_ready_o              PTW request accepted this cycle
//   dc_req_*_o / dc_req_ready_i  request to the data cache
//   dc_req_kill_o                kill forwarded to the data cache
//   dc_resp_*_i                  data-cache response
//   exe_resp_*_o / ptw_resp_*_o  response routed to its requester
//   busy_o                       a request is outstanding (EXE stall)
//   dbg_state_o                  current FSM state (drac_pkg ST_*)
//
// Handshake: a request transfers in a cycle where valid and ready are both 1;
// the requester's ready output is the arbiter's acceptance and is only high in
// the transfer cycle. The arbiter raises dc_req_valid_o only in IDLE and does
// not depend on dc_req_ready_i to decide it. Responses are single-cycle
// valid pulses with no back-pressure.
// -----------------------------------------------------------------------------
module dcache_port_arbiter
    import drac_pkg::*;
#(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              exe_req_valid_i,
    input  logic [ADDR_W-1:0] exe_req_addr_i,
    input  logic [DATA_W-1:0] exe_req_wdata_i,
    input  logic [6:0]        exe_req_op_i,
    input  logic [2:0]        exe_req_size_i,
    input  logic              exe_kill_i,
    output logic              exe_req_ready_o,

    input  logic              ptw_req_valid_i,
    input  logic [ADDR_W-1:0] ptw_req_addr_i,
    output logic              ptw_req_ready_o,

    output logic              dc_req_valid_o,
    output logic [ADDR_W-1:0] dc_req_addr_o,
    output logic [DATA_W-1:0] dc_req_wdata_o,
    output logic [6:0]        dc_req_op_o,
    output logic [2:0]        dc_req_size_o,
    output logic              dc_req_kill_o,
    input  logic              dc_req_ready_i,

    input  logic              dc_resp_valid_i,
    input  logic [DATA_W-1:0] dc_resp_data_i,
    input  logic [3:0]        dc_resp_xcpt_i,

    output logic              exe_resp_valid_o,
    output logic [DATA_W-1:0] exe_resp_data_o,
    output logic [3:0]        exe_resp_xcpt_o,

    output logic              ptw_resp_valid_o,
    output logic [DATA_W-1:0] ptw_resp_data_o,
    output logic [3:0]        ptw_resp_xcpt_o,

    output logic              busy_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic       exe_live;
    logic [1:0] grant;
    logic       timeout;

    // A killed EXE request never competes, so a PTW request still wins that cycle.
    assign exe_live = exe_req_valid_i & ~exe_kill_i;
    assign timeout  = (wait_cnt_q == TIMEOUT_CNT);

    rr_arbiter2 u_rr (
        .req_exe_i    (exe_live),
        .req_ptw_i    (ptw_req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        wait_cnt_d       = wait_cnt_q;

        exe_req_ready_o  = 1'b0;
        ptw_req_ready_o  = 1'b0;
        dc_req_valid_o   = 1'b0;
        dc_req_kill_o    = 1'b0;
        exe_resp_valid_o = 1'b0;
        exe_resp_data_o  = '0;
        exe_resp_xcpt_o  = '0;
        ptw_resp_valid_o = 1'b0;
        ptw_resp_data_o  = '0;
        ptw_resp_xcpt_o  = '0;

        // Request fields follow the granted requester; PTW has no store data.
        dc_req_addr_o    = grant[1] ? ptw_req_addr_i : exe_req_addr_i;
        dc_req_wdata_o   = grant[1] ? '0             : exe_req_wdata_i;
        dc_req_op_o      = grant[1] ? PTW_OP         : exe_req_op_i;
        dc_req_size_o    = grant[1] ? PTW_SIZE       : exe_req_size_i;

        case (state_q)
            ST_IDLE: begin
                dc_req_valid_o = |grant;
                if ((|grant) && dc_req_ready_i) begin
                    exe_req_ready_o = grant[0];
                    ptw_req_ready_o = grant[1];
                    last_grant_d    = grant[1] ? GNT_PTW : GNT_EXE;
                    wait_cnt_d      = 8'd0;
                    state_d         = grant[1] ? ST_WAIT_PTW : ST_WAIT_EXE;
                end
            end

            ST_WAIT_EXE: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (exe_kill_i) begin
                    // A response landing with the kill is simply dropped.
                    if (dc_resp_valid_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        dc_req_kill_o = 1'b1;
                        state_d       = ST_DRAIN;
                    end
                end else if (dc_resp_valid_i) begin
                    exe_resp_valid_o = 1'b1;
                    exe_resp_data_o  = dc_resp_data_i;
                    exe_resp_xcpt_o  = dc_resp_xcpt_i;
                    state_d          = ST_IDLE;
                end else if (timeout) begin
                    exe_resp_valid_o = 1'b1;
                    exe_resp_xcpt_o  = XCPT_BUS;
                    state_d          = ST_IDLE;
                end
            end

            ST_WAIT_PTW: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (dc_resp_valid_i) begin
                    ptw_resp_valid_o = 1'b1;
                    ptw_resp_data_o  = dc_resp_data_i;
                    ptw_resp_xcpt_o  = dc_resp_xcpt_i;
                    state_d          = ST_IDLE;
                end else if (timeout) begin
                    ptw_resp_valid_o = 1'b1;
                    ptw_resp_xcpt_o  = XCPT_BUS;
                    state_d          = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Swallow the killed request's response (or give up on timeout).
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (dc_resp_valid_i || timeout) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs stay quiet for the whole reset window.
        if (rst_i) begin
            exe_req_ready_o  = 1'b0;
            ptw_req_ready_o  = 1'b0;
            dc_req_valid_o   = 1'b0;
            dc_req_kill_o    = 1'b0;
            exe_resp_valid_o = 1'b0;
            ptw_resp_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_PTW;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE) & ~rst_i;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
`timescale 1ns/1ps
module tb_dcache_port_arbiter;
    import drac_pkg::*;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + 7 + 3;
    localparam int RESP_W = 1 + DATA_W + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              exe_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] exe_req_addr_i  = '0;
    logic [DATA_W-1:0] exe_req_wdata_i = '0;
    logic [6:0]        exe_req_op_i    = '0;
    logic [2:0]        exe_req_size_i  = '0;
    logic              exe_kill_i      = 1'b0;
    logic              exe_req_ready_o;
    logic              ptw_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] ptw_req_addr_i  = '0;
    logic              ptw_req_ready_o;
    logic              dc_req_valid_o;
    logic [ADDR_W-1:0] dc_req_addr_o;
    logic [DATA_W-1:0] dc_req_wdata_o;
    logic [6:0]        dc_req_op_o;
    logic [2:0]        dc_req_size_o;
    logic              dc_req_kill_o;
    logic              dc_req_ready_i  = 1'b1;
    logic              dc_resp_valid_i = 1'b0;
    logic [DATA_W-1:0] dc_resp_data_i  = '0;
    logic [3:0]        dc_resp_xcpt_i  = '0;
    logic              exe_resp_valid_o;
    logic [DATA_W-1:0] exe_resp_data_o;
    logic [3:0]        exe_resp_xcpt_o;
    logic              ptw_resp_valid_o;
    logic [DATA_W-1:0] ptw_resp_data_o;
    logic [3:0]        ptw_resp_xcpt_o;
    logic              busy_o;
    logic [1:0]        dbg_state_o;

    dcache_port_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .exe_req_valid_i  (exe_req_valid_i),
        .exe_req_addr_i   (exe_req_addr_i),
        .exe_req_wdata_i  (exe_req_wdata_i),
        .exe_req_op_i     (exe_req_op_i),
        .exe_req_size_i   (exe_req_size_i),
        .exe_kill_i       (exe_kill_i),
        .exe_req_ready_o  (exe_req_ready_o),
        .ptw_req_valid_i  (ptw_req_valid_i),
        .ptw_req_addr_i   (ptw_req_addr_i),
        .ptw_req_ready_o  (ptw_req_ready_o),
        .dc_req_valid_o   (dc_req_valid_o),
        .dc_req_addr_o    (dc_req_addr_o),
        .dc_req_wdata_o   (dc_req_wdata_o),
        .dc_req_op_o      (dc_req_op_o),
        .dc_req_size_o    (dc_req_size_o),
        .dc_req_kill_o    (dc_req_kill_o),
        .dc_req_ready_i   (dc_req_ready_i),
        .dc_resp_valid_i  (dc_resp_valid_i),
        .dc_resp_data_i   (dc_resp_data_i),
        .dc_resp_xcpt_i   (dc_resp_xcpt_i),
        .exe_resp_valid_o (exe_resp_valid_o),
        .exe_resp_data_o  (exe_resp_data_o),
        .exe_resp_xcpt_o  (exe_resp_xcpt_o),
        .ptw_resp_valid_o (ptw_resp_valid_o),
        .ptw_resp_data_o  (ptw_resp_data_o),
        .ptw_resp_xcpt_o  (ptw_resp_xcpt_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    logic [REQ_W-1:0]  exp_req_q[$];
    logic [RESP_W-1:0] exp_resp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int kill_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic              mon_src;
    logic [REQ_W-1:0]  mon_req;
    logic [RESP_W-1:0] mon_resp;

    // Monitor: compares every accepted dc request and every routed response.
    always @(negedge clk) begin
        if (dc_req_kill_o) kill_cnt++;
        if (dc_req_valid_o && dc_req_ready_i) begin
            mon_src = ptw_req_ready_o;
            check("req_one_ready", 128'(exe_req_ready_o ^ ptw_req_ready_o), 128'(1));
            mon_req = {mon_src, dc_req_addr_o, (mon_src ? {DATA_W{1'b0}} : dc_req_wdata_o),
                       dc_req_op_o, dc_req_size_o};
            if (exp_req_q.size() == 0) begin
                check("req_unexpected", 128'(mon_req), 128'(0));
            end else begin
                check("req", 128'(mon_req), 128'(exp_req_q.pop_front()));
            end
        end
        if (exe_resp_valid_o || ptw_resp_valid_o) begin
            check("resp_exclusive", 128'(exe_resp_valid_o & ptw_resp_valid_o), 128'(0));
            mon_src  = ptw_resp_valid_o;
            mon_resp = mon_src ? {1'b1, ptw_resp_data_o, ptw_resp_xcpt_o}
                               : {1'b0, exe_resp_data_o, exe_resp_xcpt_o};
            if (exp_resp_q.size() == 0) begin
                check("resp_unexpected", 128'(mon_resp), 128'(0));
            end else begin
                check("resp", 128'(mon_resp), 128'(exp_resp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_exe(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                             input logic [6:0] op, input logic [2:0] size);
        int n = 0;
        exe_req_valid_i = 1'b1;
        exe_req_addr_i  = addr;
        exe_req_wdata_i = wdata;
        exe_req_op_i    = op;
        exe_req_size_i  = size;
        exp_req_q.push_back({1'b0, addr, wdata, op, size});
        @(negedge clk);
        while (!exe_req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("exe_grant_wait", 128'(exe_req_ready_o), 128'(1));
        tick();
        exe_req_valid_i = 1'b0;
    endtask

    task automatic grant_ptw(input logic [ADDR_W-1:0] addr);
        int n = 0;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = addr;
        exp_req_q.push_back({1'b1, addr, {DATA_W{1'b0}}, PTW_OP, PTW_SIZE});
        @(negedge clk);
        while (!ptw_req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ptw_grant_wait", 128'(ptw_req_ready_o), 128'(1));
        tick();
        ptw_req_valid_i = 1'b0;
    endtask

    // One-cycle response; exp_src/expect describe where it should land.
    task automatic respond(input logic [DATA_W-1:0] data, input logic [3:0] xcpt,
                           input bit expect_it, input logic exp_src);
        if (expect_it) exp_resp_q.push_back({exp_src, data, xcpt});
        dc_resp_valid_i = 1'b1;
        dc_resp_data_i  = data;
        dc_resp_xcpt_i  = xcpt;
        tick();
        dc_resp_valid_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int early;
        // Reset with live inputs: everything must stay quiet.
        exe_req_valid_i = 1'b1;
        ptw_req_valid_i = 1'b1;
        dc_resp_valid_i = 1'b1;
        @(negedge clk);
        check("rst_dc_req_valid", 128'(dc_req_valid_o), 128'(0));
        check("rst_readies", 128'({exe_req_ready_o, ptw_req_ready_o}), 128'(0));
        check("rst_resp_valids", 128'({exe_resp_valid_o, ptw_resp_valid_o}), 128'(0));
        check("rst_kill_busy", 128'({dc_req_kill_o, busy_o}), 128'(0));
        check("rst_state", 128'(dbg_state_o), 128'(ST_IDLE));
        tick();
        exe_req_valid_i = 1'b0;
        ptw_req_valid_i = 1'b0;
        dc_resp_valid_i = 1'b0;
        rst = 1'b0;
        tick();

        // Both valid from reset: EXE first, PTW second.
        exe_req_valid_i = 1'b1;
        exe_req_addr_i  = 40'h00_1234_5678;
        exe_req_wdata_i = 64'h1111_2222_3333_4444;
        exe_req_op_i    = 7'h23;
        exe_req_size_i  = 3'd2;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_2000;
        exp_req_q.push_back({1'b0, 40'h00_1234_5678, 64'h1111_2222_3333_4444, 7'h23, 3'd2});
        exp_req_q.push_back({1'b1, 40'h00_8000_2000, {DATA_W{1'b0}}, PTW_OP, PTW_SIZE});
        @(negedge clk);
        check("tie_exe_first", 128'({exe_req_ready_o, ptw_req_ready_o}), 128'(2'b10));
        tick();
        exe_req_valid_i = 1'b0;
        @(negedge clk);
        check("wait_no_req", 128'(dc_req_valid_o), 128'(0));
        check("wait_busy", 128'(busy_o), 128'(1));
        tick();
        tick();
        respond(64'hAAAA_0000_0000_0001, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        check("ptw_second", 128'(ptw_req_ready_o), 128'(1));
        tick();
        ptw_req_valid_i = 1'b0;
        tick();
        tick();
        respond(64'h0000_0000_2000_00CF, 4'b0100, 1'b1, 1'b1);

        // PTW request held while the cache is not ready.
        dc_req_ready_i  = 1'b0;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_1000;
        exp_req_q.push_back({1'b1, 40'h00_8000_1000, {DATA_W{1'b0}}, PTW_OP, PTW_SIZE});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_valid", 128'(dc_req_valid_o), 128'(1));
            check("hold_no_ready", 128'(ptw_req_ready_o), 128'(0));
            check("hold_addr", 128'(dc_req_addr_o), 128'(40'h00_8000_1000));
            tick();
        end
        dc_req_ready_i = 1'b1;
        @(negedge clk);
        check("hold_accept", 128'(ptw_req_ready_o), 128'(1));
        tick();
        ptw_req_valid_i = 1'b0;
        @(negedge clk);
        check("hold_single_pulse", 128'(ptw_req_ready_o), 128'(0));
        tick();
        respond(64'h0000_0000_0000_BEEF, 4'b0000, 1'b1, 1'b1);

        // Kill while waiting: drain the response silently.
        kill_cnt = 0;
        grant_exe(40'h00_0000_4000, 64'd0, 7'h03, 3'd3);
        tick();
        exe_kill_i = 1'b1;
        @(negedge clk);
        check("kill_fwd", 128'(dc_req_kill_o), 128'(1));
        tick();
        exe_kill_i = 1'b0;
        @(negedge clk);
        check("drain_state", 128'(dbg_state_o), 128'(ST_DRAIN));
        tick();
        tick();
        dc_resp_valid_i = 1'b1;
        dc_resp_data_i  = 64'hDEAD;
        @(negedge clk);
        check("drain_busy", 128'(busy_o), 128'(1));
        check("drain_no_resp", 128'(exe_resp_valid_o), 128'(0));
        tick();
        dc_resp_valid_i = 1'b0;
        @(negedge clk);
        check("drain_busy_drop", 128'(busy_o), 128'(0));
        check("kill_once", 128'(kill_cnt), 128'(1));
        tick();

        // Timeout: 255 silent cycles then bus-error response.
        grant_exe(40'h00_0000_5000, 64'd0, 7'h03, 3'd3);
        early = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            if (exe_resp_valid_o) early++;
            tick();
        end
        check("to_no_early", 128'(early), 128'(0));
        exp_resp_q.push_back({1'b0, {DATA_W{1'b0}}, 4'b0001});
        @(negedge clk);
        check("to_valid", 128'(exe_resp_valid_o), 128'(1));
        tick();
        @(negedge clk);
        check("to_idle", 128'(dbg_state_o), 128'(ST_IDLE));
        check("to_not_busy", 128'(busy_o), 128'(0));
        tick();

        // Reset in WAIT_PTW; later response ignored.
        grant_ptw(40'h00_8000_3000);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 128'(dbg_state_o), 128'(ST_IDLE));
        check("mid_rst_outs", 128'({dc_req_valid_o, busy_o, ptw_resp_valid_o, exe_resp_valid_o}), 128'(0));
        tick();
        rst = 1'b0;
        dc_resp_valid_i = 1'b1;
        dc_resp_data_i  = 64'h0000_0000_0000_7777;
        @(negedge clk);
        check("post_rst_no_resp", 128'(ptw_resp_valid_o), 128'(0));
        check("post_rst_not_busy", 128'(busy_o), 128'(0));
        tick();
        dc_resp_valid_i = 1'b0;
        tick();

        // Kill and response together: dropped, new grant next cycle.
        grant_exe(40'h00_0000_6000, 64'h55, 7'h23, 3'd0);
        exe_kill_i      = 1'b1;
        dc_resp_valid_i = 1'b1;
        dc_resp_data_i  = 64'h1234;
        @(negedge clk);
        check("killresp_no_resp", 128'(exe_resp_valid_o), 128'(0));
        tick();
        exe_kill_i      = 1'b0;
        dc_resp_valid_i = 1'b0;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_4000;
        exp_req_q.push_back({1'b1, 40'h00_8000_4000, {DATA_W{1'b0}}, PTW_OP, PTW_SIZE});
        @(negedge clk);
        check("killresp_regrant", 128'(ptw_req_ready_o), 128'(1));
        tick();
        ptw_req_valid_i = 1'b0;
        respond(64'h0000_0000_0000_4444, 4'b0000, 1'b1, 1'b1);

        // Kill in IDLE: PTW still wins even though EXE would win the tie.
        exe_req_valid_i = 1'b1;
        exe_req_addr_i  = 40'h00_0000_7000;
        exe_kill_i      = 1'b1;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_5000;
        exp_req_q.push_back({1'b1, 40'h00_8000_5000, {DATA_W{1'b0}}, PTW_OP, PTW_SIZE});
        @(negedge clk);
        check("idle_kill_grant", 128'({exe_req_ready_o, ptw_req_ready_o}), 128'(2'b01));
        tick();
        exe_req_valid_i = 1'b0;
        ptw_req_valid_i = 1'b0;
        @(negedge clk);
        check("ptw_kill_ignored", 128'({dc_req_kill_o, dbg_state_o}), 128'({1'b0, ST_WAIT_PTW}));
        tick();
        respond(64'h0000_0000_0000_5555, 4'b1000, 1'b1, 1'b1);
        exe_req_valid_i = 1'b1;
        @(negedge clk);
        check("idle_kill_alone", 128'(dc_req_valid_o), 128'(0));
        tick();
        exe_req_valid_i = 1'b0;
        exe_kill_i      = 1'b0;
        tick();
        tick();

        check("req_q_empty", 128'(exp_req_q.size()), 128'(0));
        check("resp_q_empty", 128'(exp_resp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
